// File: rtl/pipelined_adder_n_bit_pkg.sv
// Shared helpers and stage control type for pipelined_adder_n_bit.
package pipelined_adder_n_bit_pkg;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Per-stage control word: the operand MSBs travel with the data so the
  // last stage can judge signed overflow without the full operands.
  typedef struct packed {
    logic valid;
    logic carry;
    logic a_msb;
    logic b_msb;
    logic ovf;
  } stage_ctrl_t;

  // Bit idx of the signed saturation value: 1000..0 when negative, 0111..1 otherwise.
  function automatic logic sat_bit(input int idx, input int width, input logic negative);
    return (idx == width - 1) ? negative : ~negative;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder_n_bit_pipe_add_chunk.sv
// Combinational CHUNK-bit ripple adder built from full_adder cells.
module pipe_add_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/pipelined_adder_n_bit.sv
// STAGES-deep add/subtract pipeline, one CHUNK of carry chain per stage, valid/ready on both sides.
// Defining PIPELINED_ADDER_SAT_EN saturates the sum on signed overflow instead of wrapping.
module pipelined_adder_n_bit
  import pipelined_adder_n_bit_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_adder_n_bit: WIDTH must be >= 2 and a multiple of STAGES");
  end

  stage_ctrl_t      ctrl_q [STAGES];
  stage_ctrl_t      ctrl_d [STAGES];
  logic [WIDTH-1:0] res_q  [STAGES];
  logic [WIDTH-1:0] res_d  [STAGES];
  logic [WIDTH-1:0] a_q    [STAGES];
  logic [WIDTH-1:0] b_q    [STAGES];
  logic [WIDTH-1:0] a_d    [STAGES];
  logic [WIDTH-1:0] b_d    [STAGES];
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] up_valid;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign b_eff = sub ? ~b : b;
  assign c0    = cin ^ sub;

  // A stage may take new data when it is empty or its contents move on this
  // edge; the chain runs from the output back so bubbles collapse.
  always_comb begin
    adv = '0;
    up_valid = '0;
    adv[STAGES-1] = !ctrl_q[STAGES-1].valid || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !ctrl_q[k].valid || adv[k+1];
    end
    up_valid[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      up_valid[k] = ctrl_q[k-1].valid;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res_in;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] res_store;
    logic [CHUNK-1:0] chunk_sum;
    logic             carry_in;
    logic             chunk_carry;
    logic             a_msb_in;
    logic             b_msb_in;
    logic             ovf_next;

    if (k == 0) begin : g_first
      assign op_a     = a;
      assign op_b     = b_eff;
      assign carry_in = c0;
      assign res_in   = '0;
      assign a_msb_in = a[WIDTH-1];
      assign b_msb_in = b_eff[WIDTH-1];
    end else begin : g_rest
      assign op_a     = a_q[k-1];
      assign op_b     = b_q[k-1];
      assign carry_in = ctrl_q[k-1].carry;
      assign res_in   = res_q[k-1];
      assign a_msb_in = ctrl_q[k-1].a_msb;
      assign b_msb_in = ctrl_q[k-1].b_msb;
    end

    pipe_add_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (op_a[k*CHUNK +: CHUNK]),
      .b    (op_b[k*CHUNK +: CHUNK]),
      .cin  (carry_in),
      .s    (chunk_sum),
      .cout (chunk_carry)
    );

    always_comb begin
      res_next = res_in;
      res_next[k*CHUNK +: CHUNK] = chunk_sum;
    end

    // Only meaningful in the last stage, where every chunk is present.
    assign ovf_next = (a_msb_in == b_msb_in) && (res_next[WIDTH-1] != a_msb_in);

`ifdef PIPELINED_ADDER_SAT_EN
    if (k == STAGES - 1) begin : g_sat
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign res_store[i] = ovf_next ? sat_bit(i, WIDTH, a_msb_in) : res_next[i];
      end
    end else begin : g_nosat
      assign res_store = res_next;
    end
`else
    assign res_store = res_next;
`endif

    assign res_d[k]  = res_store;
    assign a_d[k]    = op_a;
    assign b_d[k]    = op_b;
    assign ctrl_d[k] = '{valid: 1'b1, carry: chunk_carry, a_msb: a_msb_in,
                         b_msb: b_msb_in, ovf: ovf_next};
  end

  // Payload only loads alongside a valid token, so a stalled or empty
  // stage keeps its last contents and the outputs hold steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        ctrl_q[k] <= '0;
        res_q[k]  <= '0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          if (up_valid[k]) begin
            ctrl_q[k] <= ctrl_d[k];
            res_q[k]  <= res_d[k];
            a_q[k]    <= a_d[k];
            b_q[k]    <= b_d[k];
          end else begin
            ctrl_q[k].valid <= 1'b0;
          end
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = ctrl_q[STAGES-1].valid;
  assign sum       = res_q[STAGES-1];
  assign cout      = ctrl_q[STAGES-1].carry;
  assign ovf       = ctrl_q[STAGES-1].ovf;

endmodule
